tx_wm_fifo: RTL and testbench

Parametrised TX-path FIFO with programmable low/high watermarks, captured during an init phase, plus sticky overflow/underflow error reporting. It is the reusable buffer for the main, VC0/VC1 and D0/D1 stages of the transmitter, replacing fixed-width, fixed-depth copies. A small control FSM sequences init, idle and active operation. Thresholds drive almost_empty/almost_full, which feed upstream arbitration and flow control.

---
 rtl/tx_wm_fifo.sv | 92 +++++++++
 tb/tb_tx_wm_fifo.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/tx_wm_fifo.sv
// tx_wm_fifo: TX-path FIFO with init-captured low/high watermarks and sticky overflow/underflow error.
// Registered read port: data_out/valid_out appear the cycle after an accepted pop.
module tx_wm_fifo #(
    parameter  int DATA_W = 6,
    parameter  int DEPTH  = 8,
    localparam int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              RESET_L,
    input  logic              init,
    input  logic              push,
    input  logic              pop,
    input  logic [DATA_W-1:0] data_in,
    input  logic [CNT_W-1:0]  th_low,
    input  logic [CNT_W-1:0]  th_high,
    output logic [DATA_W-1:0] data_out,
    output logic              valid_out,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty,
    output logic              almost_full,
    output logic              almost_empty,
    output logic              error,
    output logic [1:0]        state
);
    localparam int PW = $clog2(DEPTH);

    typedef enum logic [1:0] {INIT = 2'd0, IDLE = 2'd1, ACTIVE = 2'd2} state_t;

    state_t            state_q, state_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d, low_q, low_d, high_q, high_d;
    logic [DATA_W-1:0] data_out_q, data_out_d;
    logic              valid_q, valid_d, error_q, error_d;
    logic              act, push_acc, pop_acc;

    always_comb begin
        act        = (state_q != INIT) && !init;
        pop_acc    = act && pop && (count_q != '0);
        // a pop in the same cycle frees a slot, so push+pop on a full FIFO is legal
        push_acc   = act && push && ((count_q != CNT_W'(DEPTH)) || pop_acc);
        error_d    = init ? 1'b0 : error_q | (act && ((push && !push_acc) || (pop && !pop_acc)));
        wr_ptr_d   = init ? '0 : wr_ptr_q + PW'(push_acc);
        rd_ptr_d   = init ? '0 : rd_ptr_q + PW'(pop_acc);
        count_d    = init ? '0 : count_q + CNT_W'(push_acc) - CNT_W'(pop_acc);
        state_d    = init ? INIT : ((count_d == '0) ? IDLE : ACTIVE);
        low_d      = (state_q == INIT) ? th_low : low_q;
        high_d     = (state_q == INIT) ? th_high : high_q;
        valid_d    = pop_acc;
        data_out_d = pop_acc ? mem_q[rd_ptr_q] : data_out_q;
    end

    always_ff @(posedge clk or negedge RESET_L) begin
        if (!RESET_L) begin
            state_q    <= INIT;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            low_q      <= CNT_W'(1);
            high_q     <= CNT_W'(DEPTH - 1);
            data_out_q <= '0;
            valid_q    <= 1'b0;
            error_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            low_q      <= low_d;
            high_q     <= high_d;
            data_out_q <= data_out_d;
            valid_q    <= valid_d;
            error_q    <= error_d;
        end
    end

    // storage is not reset; init and reset only rewind the pointers
    always_ff @(posedge clk) begin
        if (push_acc) mem_q[wr_ptr_q] <= data_in;
    end

    assign data_out     = data_out_q;
    assign valid_out    = valid_q;
    assign count        = count_q;
    assign error        = error_q;
    assign state        = state_q;
    assign full         = count_q == CNT_W'(DEPTH);
    assign empty        = count_q == '0;
    assign almost_full  = count_q >= high_q;
    assign almost_empty = count_q <= low_q;
endmodule

// File: tb/tb_tx_wm_fifo.sv
// tb_tx_wm_fifo: directed stimulus with a queue scoreboard; a negedge monitor checks every valid_out word.
module tb_tx_wm_fifo;
    localparam int DATA_W = 6;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    logic              clk = 1'b0;
    logic              RESET_L, init, push, pop;
    logic [DATA_W-1:0] data_in, data_out;
    logic [CNT_W-1:0]  th_low, th_high, count;
    logic              valid_out, full, empty, almost_full, almost_empty, error;
    logic [1:0]        state;

    int compared = 0;
    int mismatched = 0;
    logic [DATA_W-1:0] exp_q[$];

    tx_wm_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk(clk), .RESET_L(RESET_L), .init(init), .push(push), .pop(pop),
        .data_in(data_in), .th_low(th_low), .th_high(th_high),
        .data_out(data_out), .valid_out(valid_out), .count(count), .full(full),
        .empty(empty), .almost_full(almost_full), .almost_empty(almost_empty),
        .error(error), .state(state)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        compared++;
        if (act != exp) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    always @(negedge clk) begin
        if (valid_out) begin
            if (exp_q.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_valid: got data %0d expected no output", data_out);
            end else begin
                chk("data_out", int'(data_out), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        RESET_L = 1'b0; init = 1'b0; push = 1'b0; pop = 1'b0;
        data_in = '0; th_low = 4'd1; th_high = 4'd3;
        #12;
        chk("rst_state", int'(state), 0);
        chk("rst_count", int'(count), 0);
        chk("rst_empty", int'(empty), 1);
        chk("rst_full", int'(full), 0);
        chk("rst_ae", int'(almost_empty), 1);
        chk("rst_af", int'(almost_full), 0);
        chk("rst_err", int'(error), 0);
        chk("rst_valid", int'(valid_out), 0);
        chk("rst_dout", int'(data_out), 0);
        step();
        RESET_L = 1'b1;
        // test 1: init capture then IDLE
        init = 1'b1;
        step();
        chk("t1_state_init", int'(state), 0);
        init = 1'b0;
        step();
        chk("t1_state_idle", int'(state), 1);
        chk("t1_empty", int'(empty), 1);
        chk("t1_ae", int'(almost_empty), 1);
        chk("t1_err", int'(error), 0);
        // test 2: single word round trip
        push = 1'b1; data_in = 6'b101010; exp_q.push_back(6'b101010);
        step();
        push = 1'b0;
        chk("t2_count", int'(count), 1);
        chk("t2_state", int'(state), 2);
        step();
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("t2_valid", int'(valid_out), 1);
        chk("t2_state_idle", int'(state), 1);
        chk("t2_empty", int'(empty), 1);
        step();
        chk("t2_valid_pulse", int'(valid_out), 0);
        // test 3: fill, overflow, drain with wrap
        for (int i = 0; i < DEPTH; i++) begin
            push = 1'b1; data_in = DATA_W'(i); exp_q.push_back(DATA_W'(i));
            step();
            chk("t3_count", int'(count), i + 1);
            chk("t3_af", int'(almost_full), (i + 1 >= 3) ? 1 : 0);
            chk("t3_full", int'(full), (i + 1 == DEPTH) ? 1 : 0);
        end
        data_in = 6'd9;
        step();
        push = 1'b0;
        chk("t3_ovf_count", int'(count), 8);
        chk("t3_ovf_err", int'(error), 1);
        pop = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            step();
            chk("t3_drain_count", int'(count), DEPTH - 1 - i);
        end
        pop = 1'b0;
        init = 1'b1;
        step();
        init = 1'b0;
        step();
        chk("t3_init_err", int'(error), 0);
        chk("t3_init_state", int'(state), 1);
        // test 4: push+pop while full
        push = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            data_in = DATA_W'(10 + i); exp_q.push_back(DATA_W'(10 + i));
            step();
        end
        pop = 1'b1; data_in = 6'h2A; exp_q.push_back(6'h2A);
        step();
        push = 1'b0;
        chk("t4_count", int'(count), 8);
        chk("t4_err", int'(error), 0);
        chk("t4_full", int'(full), 1);
        for (int i = 0; i < DEPTH; i++) step();
        pop = 1'b0;
        chk("t4_empty", int'(empty), 1);
        step();
        step();
        // test 5: underflow, push+pop on empty, init clears error
        pop = 1'b1;
        step();
        pop = 1'b0;
        chk("t5_unf_err", int'(error), 1);
        chk("t5_unf_valid", int'(valid_out), 0);
        push = 1'b1; pop = 1'b1; data_in = 6'h15;
        step();
        push = 1'b0; pop = 1'b0;
        chk("t5_pp_count", int'(count), 1);
        chk("t5_pp_err", int'(error), 1);
        th_low = 4'd9; th_high = 4'd0;
        init = 1'b1;
        step();
        init = 1'b0;
        chk("t5_init_err", int'(error), 0);
        chk("t5_init_count", int'(count), 0);
        chk("t5_init_state", int'(state), 0);
        step();
        // test 6: th_low>=DEPTH, th_high==0, then async reset mid-stream
        chk("t6_af_zero_th", int'(almost_full), 1);
        push = 1'b1;
        for (int i = 0; i < 5; i++) begin
            data_in = DATA_W'(40 + i); exp_q.push_back(DATA_W'(40 + i));
            step();
        end
        push = 1'b0;
        chk("t6_count", int'(count), 5);
        chk("t6_ae_big_th", int'(almost_empty), 1);
        chk("t6_af_big", int'(almost_full), 1);
        #3;
        RESET_L = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_rst_count", int'(count), 0);
        chk("t6_rst_state", int'(state), 0);
        chk("t6_rst_empty", int'(empty), 1);
        chk("t6_rst_ae", int'(almost_empty), 1);
        chk("t6_rst_af", int'(almost_full), 0);
        chk("t6_rst_err", int'(error), 0);
        step();
        RESET_L = 1'b1;
        step();
        step();
        chk("sb_left", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
